lzd_pipe: RTL

//  Parametrised, pipelined leading-zero detector. Built as a log2 tree of 2-way merge nodes.

---
 rtl/lzd_pkg.sv | 19 +
 rtl/lzd_pipe_if.sv | 11 +
 rtl/lzd_merge.sv | 12 +
 rtl/lzd_pipe.sv | 130 +++++++++++++
 4 files changed

// File: rtl/lzd_pkg.sv
// lzd_pkg: shared constants, tree-split helpers and node type for lzd_pipe
package lzd_pkg;
  localparam int LZD_MAX_W = 64;
  typedef struct packed {
    logic v;
    logic [$clog2(LZD_MAX_W)-1:0] p;
  } lzd_node_t;
  function automatic int lzd_levels(input int w);
    return $clog2(w);
  endfunction
  // First (levels % stages) stages take one extra tree level
  function automatic int lzd_stage_of_level(input int lvl, input int levels, input int stages);
    int base;
    int extra;
    base = levels / stages;
    extra = levels % stages;
    return (lvl < extra * (base + 1)) ? lvl / (base + 1) : extra + (lvl - extra * (base + 1)) / base;
  endfunction
endpackage

// File: rtl/lzd_pipe_if.sv
// lzd_pipe_if: valid/ready stream bundle; master = producer/consumer side, slave = lzd_pipe
interface lzd_pipe_if #(parameter int WIDTH = 32, parameter int TAG_W = 4);
  logic in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [WIDTH-1:0] in_data, out_norm;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [$clog2(WIDTH)-1:0] out_count;
  modport master(output in_valid, in_data, in_tag, out_ready,
                 input in_ready, out_valid, out_count, out_zero, out_norm, out_tag);
  modport slave(input in_valid, in_data, in_tag, out_ready,
                output in_ready, out_valid, out_count, out_zero, out_norm, out_tag);
endinterface

// File: rtl/lzd_merge.sv
// lzd_merge: combinational 2-way merge node (upper/lower {v,p}) of the leading-zero tree
module lzd_merge #(parameter int PW = 1) (
  input  logic          v_u,
  input  logic          v_l,
  input  logic [PW-1:0] p_u,
  input  logic [PW-1:0] p_l,
  output logic          v,
  output logic [PW:0]   p
);
  assign v = v_u | v_l;
  assign p = {~v_u, v_u ? p_u : p_l};
endmodule

// File: rtl/lzd_pipe.sv
// lzd_pipe: pipelined leading-zero detector with valid/ready stream on both sides
// Ports: clk, rst_n (async active-low), bus (lzd_pipe_if.slave: in_valid/in_ready/in_data/in_tag,
//        out_valid/out_ready/out_count/out_zero/out_norm/out_tag)
// LZD_SHIFT_EN: adds an output stage producing out_norm = in_data << out_count
module lzd_pipe import lzd_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input logic      clk,
  input logic      rst_n,
  lzd_pipe_if.slave bus
);
  localparam int L = lzd_levels(WIDTH);
`ifdef LZD_SHIFT_EN
  localparam int NS = STAGES + 1;
`else
  localparam int NS = STAGES;
`endif
  logic [NS-1:0] vld, adv, vin, ld;
  logic [TAG_W-1:0] tag_q [NS];
  logic [TAG_W-1:0] tag_d [NS];
  logic rdy, chain, root_v;
  logic [L-1:0] root_p;
  // Holds in_ready low through reset and releases it one edge later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdy <= 1'b0;
    else rdy <= 1'b1;
  // A stage may advance if it is empty or everything downstream advances
  always_comb begin
    chain = bus.out_ready;
    adv = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      adv[k] = ~vld[k] | chain;
      chain = adv[k];
    end
  end
  assign bus.in_ready = adv[0] & rdy;
  assign vin = NS'({vld, bus.in_valid & bus.in_ready});
  assign ld = adv & vin;
  always_comb begin
    tag_d[0] = bus.in_tag;
    for (int k = 1; k < NS; k++) tag_d[k] = tag_q[k-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < NS; k++) tag_q[k] <= '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (adv[k]) vld[k] <= vin[k];
        if (ld[k]) tag_q[k] <= tag_d[k];
      end
    end
  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int N  = WIDTH >> (l + 1);
    localparam int PW = l + 1;
    localparam int S  = lzd_stage_of_level(l, L, STAGES);
    logic [N-1:0] v, vo;
    logic [N*PW-1:0] p, po;
    if (l == 0) begin : g_leaf
      for (genvar n = 0; n < N; n++) begin : g_n
        assign v[n] = bus.in_data[2*n+1] | bus.in_data[2*n];
        assign p[n] = ~bus.in_data[2*n+1];
      end
    end else begin : g_mrg
      for (genvar n = 0; n < N; n++) begin : g_n
        lzd_merge #(.PW(l)) u_m (
          .v_u(g_lvl[l-1].vo[2*n+1]),
          .v_l(g_lvl[l-1].vo[2*n]),
          .p_u(g_lvl[l-1].po[(2*n+1)*l +: l]),
          .p_l(g_lvl[l-1].po[2*n*l +: l]),
          .v(v[n]),
          .p(p[n*PW +: PW])
        );
      end
    end
    // Register only the last level of each stage
    if (l == L - 1 || lzd_stage_of_level(l + 1, L, STAGES) != S) begin : g_reg
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          vo <= '0;
          po <= '0;
        end else if (ld[S]) begin
          vo <= v;
          po <= p;
        end
    end else begin : g_thru
      assign vo = v;
      assign po = p;
    end
  end
  assign root_v = g_lvl[L-1].vo[0];
  assign root_p = g_lvl[L-1].po;
  assign bus.out_valid = vld[NS-1];
  assign bus.out_tag = tag_q[NS-1];
`ifdef LZD_SHIFT_EN
  logic [WIDTH-1:0] dat_q [STAGES];
  logic [WIDTH-1:0] dat_d [STAGES];
  logic [L-1:0] cnt_q;
  logic zero_q;
  logic [WIDTH-1:0] norm_q;
  always_comb begin
    dat_d[0] = bus.in_data;
    for (int k = 1; k < STAGES; k++) dat_d[k] = dat_q[k-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) dat_q[k] <= '0;
      cnt_q <= '0;
      zero_q <= 1'b0;
      norm_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (ld[k]) dat_q[k] <= dat_d[k];
      if (ld[STAGES]) begin
        cnt_q <= root_p;
        zero_q <= ~root_v;
        norm_q <= root_v ? dat_q[STAGES-1] << root_p : '0;
      end
    end
  assign bus.out_count = cnt_q;
  assign bus.out_zero = zero_q;
  assign bus.out_norm = norm_q;
`else
  assign bus.out_count = root_p;
  assign bus.out_zero = vld[NS-1] & ~root_v;
  assign bus.out_norm = '0;
`endif
endmodule
